axi4_lite_master_arbiter: RTL and testbench

AXI4_LITE_MASTER_ARBITER -- requirements
Module: axi4_lite_master_arbiter

---
 rtl/axi4_lite_master_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_axi4_lite_master_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master_arbiter.sv
// Two-requester round-robin front end onto a single AXI4-Lite master port.
// One transaction in flight at a time; every output comes straight from a flop.
module axi4_lite_master_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [1:0]                  req_valid,
  input  logic [1:0]                  req_write,
  input  logic [2*ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [2*DATA_WIDTH-1:0]     req_wdata,
  input  logic [2*(DATA_WIDTH/8)-1:0] req_wstrb,
  input  logic [5:0]                  req_prot,
  output logic [1:0]                  req_ready,
  output logic [1:0]                  rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic [ADDRESS_WIDTH-1:0]    awaddr,
  output logic [2:0]                  awprot,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [DATA_WIDTH-1:0]       wdata,
  output logic [DATA_WIDTH/8-1:0]     wstrb,
  output logic                        wvalid,
  input  logic                        wready,
  input  logic [1:0]                  bresp,
  input  logic                        bvalid,
  output logic                        bready,
  output logic [ADDRESS_WIDTH-1:0]    araddr,
  output logic [2:0]                  arprot,
  output logic                        arvalid,
  input  logic                        arready,
  input  logic [DATA_WIDTH-1:0]       rdata,
  input  logic [1:0]                  rresp,
  input  logic                        rvalid,
  output logic                        rready
);

  localparam int unsigned AW     = ADDRESS_WIDTH;
  localparam int unsigned DW     = DATA_WIDTH;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WADDR = 3'd1;
  localparam logic [2:0] WRESP = 3'd2;
  localparam logic [2:0] RADDR = 3'd3;
  localparam logic [2:0] RDATA = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [1:0]        req_ready_q, req_ready_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic [AW-1:0]     awaddr_q, awaddr_d;
  logic [2:0]        awprot_q, awprot_d;
  logic              awvalid_q, awvalid_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic [AW-1:0]     araddr_q, araddr_d;
  logic [2:0]        arprot_q, arprot_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;

  logic              sel;
  logic              aw_ok;
  logic              w_ok;

  // Round-robin pick: alternate on contention, otherwise take the lone requester.
  always_comb begin
    sel = 1'b0;
    if (req_valid == 2'b11) sel = ~last_grant_q;
    else                    sel = req_valid[1];
  end

  // Next-state and output computation.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    req_ready_d  = 2'b00;
    rsp_valid_d  = 2'b00;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_resp_d   = rsp_resp_q;
    awaddr_d     = awaddr_q;
    awprot_d     = awprot_q;
    awvalid_d    = awvalid_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    araddr_d     = araddr_q;
    arprot_d     = arprot_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    aw_ok        = aw_done_q | (awvalid_q & awready);
    w_ok         = w_done_q  | (wvalid_q & wready);

    case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          req_ready_d  = sel ? 2'b10 : 2'b01;
          grant_d      = sel;
          last_grant_d = sel;
          aw_done_d    = 1'b0;
          w_done_d     = 1'b0;
          if (sel ? req_write[1] : req_write[0]) begin
            state_d  = WADDR;
            awaddr_d = sel ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
            awprot_d = sel ? req_prot[5:3] : req_prot[2:0];
            wdata_d  = sel ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
            wstrb_d  = sel ? req_wstrb[2*STRB_W-1:STRB_W] : req_wstrb[STRB_W-1:0];
          end else begin
            state_d  = RADDR;
            araddr_d = sel ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
            arprot_d = sel ? req_prot[5:3] : req_prot[2:0];
          end
        end
      end
      WADDR: begin
        if (req_ready_q != 2'b00) begin
          // Grant cycle: raise both VALIDs for the following cycle.
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else begin
          if (awvalid_q && awready) begin
            awvalid_d = 1'b0;
            aw_done_d = 1'b1;
          end
          if (wvalid_q && wready) begin
            wvalid_d = 1'b0;
            w_done_d = 1'b1;
          end
          if (aw_ok && w_ok) begin
            state_d  = WRESP;
            bready_d = 1'b1;
          end
        end
      end
      WRESP: begin
        if (bvalid) begin
          rsp_resp_d  = bresp;
          rsp_rdata_d = '0;
          rsp_valid_d = grant_q ? 2'b10 : 2'b01;
          bready_d    = 1'b0;
          state_d     = IDLE;
        end
      end
      RADDR: begin
        if (req_ready_q != 2'b00) begin
          arvalid_d = 1'b1;
        end else if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (rvalid) begin
          rsp_resp_d  = rresp;
          rsp_rdata_d = rdata;
          rsp_valid_d = grant_q ? 2'b10 : 2'b01;
          rready_d    = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      req_ready_q  <= 2'b00;
      rsp_valid_q  <= 2'b00;
      rsp_rdata_q  <= '0;
      rsp_resp_q   <= 2'b00;
      awaddr_q     <= '0;
      awprot_q     <= 3'b000;
      awvalid_q    <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      araddr_q     <= '0;
      arprot_q     <= 3'b000;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_resp_q   <= rsp_resp_d;
      awaddr_q     <= awaddr_d;
      awprot_q     <= awprot_d;
      awvalid_q    <= awvalid_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      araddr_q     <= araddr_d;
      arprot_q     <= arprot_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign awaddr    = awaddr_q;
  assign awprot    = awprot_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign araddr    = araddr_q;
  assign arprot    = arprot_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_arbiter.sv
// Directed bench for the two-requester AXI4-Lite master arbiter.
module tb_axi4_lite_master_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic              aclk;
  logic              aresetn;
  logic [1:0]        req_valid;
  logic [1:0]        req_write;
  logic [2*AW-1:0]   req_addr;
  logic [2*DW-1:0]   req_wdata;
  logic [2*SW-1:0]   req_wstrb;
  logic [5:0]        req_prot;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic [1:0]        rsp_resp;
  logic [AW-1:0]     awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DW-1:0]     wdata;
  logic [SW-1:0]     wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [AW-1:0]     araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  int passed;
  int total;

  axi4_lite_master_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_prot(req_prot),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Advance one cycle and settle just past the rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Wait (bounded) for any req_ready pulse; returns the observed vector.
  task automatic wait_grant(input string name, output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_ready != 2'b00) begin
        g = req_ready;
        break;
      end
    end
    total++;
    if (g == 2'b00) $display("FAIL %s: no req_ready within 20 cycles", name);
    else passed++;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_resp, awaddr, awprot, awvalid, wdata, wstrb,
         wvalid, bready, araddr, arprot, arvalid, rready} !== '0)
      $display("FAIL reset_outputs: some output nonzero during reset");
    else passed++;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_write_basic();
    logic [1:0] g;
    req_write = 2'b01;
    req_addr  = {32'h0, 32'h0000_0010};
    req_wdata = {32'h0, 32'hA5A5_A5A5};
    req_wstrb = {4'h0, 4'hF};
    req_prot  = 6'b000_010;
    req_valid = 2'b01;
    wait_grant("wr_grant", g);
    req_valid = 2'b00;
    total++; if (g !== 2'b01) $display("FAIL wr_grant_id: got %b exp 01", g); else passed++;
    tick(); // T+1
    awready = 1'b1; wready = 1'b1;
    total++; if (req_ready !== 2'b00) $display("FAIL wr_ready_pulse: got %b exp 00", req_ready); else passed++;
    total++; if ({awvalid, wvalid} !== 2'b11) $display("FAIL wr_valids: got %b exp 11", {awvalid, wvalid}); else passed++;
    total++; if (awaddr !== 32'h10) $display("FAIL wr_awaddr: got %h exp 00000010", awaddr); else passed++;
    total++; if ({wdata, wstrb, awprot} !== {32'hA5A5_A5A5, 4'hF, 3'b010})
      $display("FAIL wr_payload: got %h/%h/%b", wdata, wstrb, awprot); else passed++;
    tick(); // T+2
    awready = 1'b0; wready = 1'b0;
    total++; if ({awvalid, wvalid, bready} !== 3'b001) $display("FAIL wr_to_wresp: got %b exp 001", {awvalid, wvalid, bready}); else passed++;
    tick(); // T+3
    bvalid = 1'b1; bresp = 2'b00;
    total++; if (rsp_valid !== 2'b00) $display("FAIL wr_early_rsp: got %b exp 00", rsp_valid); else passed++;
    tick(); // T+4
    bvalid = 1'b0;
    total++; if (rsp_valid !== 2'b01) $display("FAIL wr_rsp_valid: got %b exp 01", rsp_valid); else passed++;
    total++; if ({rsp_resp, rsp_rdata, bready} !== {2'b00, 32'h0, 1'b0})
      $display("FAIL wr_rsp_fields: got resp %b rdata %h bready %b", rsp_resp, rsp_rdata, bready); else passed++;
    tick(); // T+5
    total++; if (rsp_valid !== 2'b00) $display("FAIL wr_rsp_pulse: got %b exp 00", rsp_valid); else passed++;
  endtask

  task automatic test_read_basic();
    logic [1:0] g;
    req_write = 2'b00;
    req_addr  = {32'h0000_0020, 32'h0};
    req_prot  = 6'b101_000;
    req_valid = 2'b10;
    wait_grant("rd_grant", g);
    req_valid = 2'b00;
    total++; if (g !== 2'b10) $display("FAIL rd_grant_id: got %b exp 10", g); else passed++;
    tick(); // T+1
    total++; if ({arvalid, araddr, arprot} !== {1'b1, 32'h20, 3'b101})
      $display("FAIL rd_ar_t1: got valid %b addr %h prot %b", arvalid, araddr, arprot); else passed++;
    tick(); // T+2
    arready = 1'b1;
    total++; if ({arvalid, araddr} !== {1'b1, 32'h20}) $display("FAIL rd_ar_t2: got valid %b addr %h", arvalid, araddr); else passed++;
    tick(); // T+3
    arready = 1'b0;
    total++; if ({arvalid, rready} !== 2'b01) $display("FAIL rd_to_rdata: got %b exp 01", {arvalid, rready}); else passed++;
    tick(); // T+4
    rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
    tick(); // T+5
    rvalid = 1'b0;
    total++; if (rsp_valid !== 2'b10) $display("FAIL rd_rsp_valid: got %b exp 10", rsp_valid); else passed++;
    total++; if (rsp_rdata !== 32'h1234_5678) $display("FAIL rd_rdata: got %h exp 12345678", rsp_rdata); else passed++;
    tick();
    total++; if ({rsp_valid, rready, rsp_rdata} !== {2'b00, 1'b0, 32'h1234_5678})
      $display("FAIL rd_after: rsp_valid %b rready %b rdata %h", rsp_valid, rready, rsp_rdata); else passed++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4];
    logic [1:0] got_g [4];
    int n_grant;
    int n0;
    int n1;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    n_grant = 0; n0 = 0; n1 = 0;
    req_write = 2'b00;
    req_addr  = {32'h0000_0200, 32'h0000_0100};
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hCAFE_0001; rresp = 2'b00;
    req_valid = 2'b11;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (rsp_valid[0]) n0++;
      if (rsp_valid[1]) n1++;
      if (req_ready != 2'b00 && n_grant < 4) begin
        got_g[n_grant] = req_ready;
        n_grant++;
        if (n_grant == 4) req_valid = 2'b00;
      end
    end
    arready = 1'b0; rvalid = 1'b0;
    total++; if (n_grant !== 4) $display("FAIL rr_grant_count: got %0d exp 4", n_grant); else passed++;
    for (int k = 0; k < 4; k++) begin
      if (k < n_grant) begin
        total++;
        if (got_g[k] !== exp_g[k]) $display("FAIL rr_grant%0d: got %b exp %b", k, got_g[k], exp_g[k]);
        else passed++;
      end
    end
    total++; if (n0 !== 2 || n1 !== 2) $display("FAIL rr_rsp_counts: got %0d/%0d exp 2/2", n0, n1); else passed++;
  endtask

  task automatic test_write_split();
    logic [1:0] g;
    int extra;
    req_write = 2'b01;
    req_addr  = {32'h0, 32'h0000_0044};
    req_wdata = {32'h0, 32'h0BAD_F00D};
    req_wstrb = {4'h0, 4'h3};
    req_valid = 2'b01;
    wait_grant("split_grant", g);
    req_valid = 2'b00;
    tick(); // T+1
    wready = 1'b1;
    total++; if ({awvalid, wvalid} !== 2'b11) $display("FAIL split_valids_t1: got %b exp 11", {awvalid, wvalid}); else passed++;
    tick(); // T+2
    wready = 1'b0;
    total++; if ({awvalid, wvalid} !== 2'b10) $display("FAIL split_wdrop: got %b exp 10", {awvalid, wvalid}); else passed++;
    tick(); // T+3
    total++; if ({awvalid, awaddr, bready} !== {1'b1, 32'h44, 1'b0})
      $display("FAIL split_awhold: valid %b addr %h bready %b", awvalid, awaddr, bready); else passed++;
    tick(); // T+4
    awready = 1'b1;
    tick(); // T+5
    awready = 1'b0;
    total++; if ({awvalid, wvalid, bready} !== 3'b001) $display("FAIL split_wresp: got %b exp 001", {awvalid, wvalid, bready}); else passed++;
    tick(); // T+6
    bvalid = 1'b1; bresp = 2'b00;
    tick(); // T+7
    bvalid = 1'b0;
    total++; if (rsp_valid !== 2'b01) $display("FAIL split_rsp: got %b exp 01", rsp_valid); else passed++;
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (rsp_valid != 2'b00) extra++;
    end
    total++; if (extra !== 0) $display("FAIL split_single_rsp: extra pulses %0d exp 0", extra); else passed++;
  endtask

  task automatic test_read_error();
    logic [1:0] g;
    req_write = 2'b00;
    req_addr  = {32'h0000_0300, 32'h0};
    req_valid = 2'b10;
    wait_grant("err_grant", g);
    req_valid = 2'b00;
    tick(); // T+1
    arready = 1'b1;
    tick(); // T+2
    arready = 1'b0;
    rvalid = 1'b1; rresp = 2'b10; rdata = 32'hDEAD_BEEF;
    tick(); // T+3
    rvalid = 1'b0;
    total++; if ({rsp_valid, rsp_resp} !== {2'b10, 2'b10}) $display("FAIL err_rsp: valid %b resp %b exp 10/10", rsp_valid, rsp_resp); else passed++;
    total++; if (rsp_rdata !== 32'hDEAD_BEEF) $display("FAIL err_rdata: got %h exp deadbeef", rsp_rdata); else passed++;
    // A fresh request is accepted, so the FSM has gone back to IDLE without retrying.
    req_addr  = {32'h0, 32'h0000_0400};
    req_valid = 2'b01;
    wait_grant("err_next_grant", g);
    req_valid = 2'b00;
    total++; if (g !== 2'b01) $display("FAIL err_next_id: got %b exp 01", g); else passed++;
    tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rresp = 2'b00;
    tick();
    rvalid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midflight();
    logic [1:0] g;
    int pulses;
    req_write = 2'b01;
    req_addr  = {32'h0, 32'h0000_0500};
    req_wdata = {32'h0, 32'h5555_AAAA};
    req_valid = 2'b01;
    wait_grant("rst_grant", g);
    req_valid = 2'b00;
    tick();
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    total++; if (bready !== 1'b1) $display("FAIL rst_in_wresp: bready %b exp 1", bready); else passed++;
    #2;
    bvalid = 1'b1;
    aresetn = 1'b0;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_resp, awaddr, awprot, awvalid, wdata, wstrb,
         wvalid, bready, araddr, arprot, arvalid, rready} !== '0)
      $display("FAIL rst_mid_outputs: some output nonzero during reset");
    else passed++;
    pulses = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (rsp_valid != 2'b00) pulses++;
    end
    bvalid = 1'b0;
    aresetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (rsp_valid != 2'b00) pulses++;
    end
    total++; if (pulses !== 0) $display("FAIL rst_no_rsp: got %0d pulses exp 0", pulses); else passed++;
    req_write = 2'b00;
    req_valid = 2'b11;
    wait_grant("rst_post_grant", g);
    req_valid = 2'b00;
    total++; if (g !== 2'b01) $display("FAIL rst_post_id: got %b exp 01", g); else passed++;
  endtask

  initial begin
    passed = 0; total = 0;
    aresetn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0; req_prot = '0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
    #3;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_round_robin();
    test_write_split();
    test_read_error();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
